// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester channels and the shared RAM port seen by ram_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-RAM side.
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  r0_valid;
    logic                  r0_ready;
    logic                  r0_we;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic                  r0_rvalid;
    logic [DATA_WIDTH-1:0] r0_rdata;

    logic                  r1_valid;
    logic                  r1_ready;
    logic                  r1_we;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic                  r1_rvalid;
    logic [DATA_WIDTH-1:0] r1_rdata;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        output r0_ready, r0_rvalid, r0_rdata,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        output r1_ready, r1_rvalid, r1_rdata,
        output ram_en, ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        input  r0_ready, r0_rvalid, r0_rdata,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        input  r1_ready, r1_rvalid, r1_rdata,
        input  ram_en, ram_we, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter with bounded burst lock in front of one RAM port
// (0 = DMA loader, 1 = compute engine); routes 1-cycle-latency read data back to the issuer.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 4
) (
    input logic clk,
    input logic rst,
    ram_port_arbiter_if.slave bus
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST - 1);

    logic [1:0]            req_valid;
    logic [1:0]            req_we;
    logic [ADDR_WIDTH-1:0] req_addr  [2];
    logic [DATA_WIDTH-1:0] req_wdata [2];
    logic [1:0]            gnt_vec;
    logic [1:0]            rvalid_vec;

    logic             last_gnt_reg,   last_gnt_next;
    logic [CNT_W-1:0] burst_cnt_reg,  burst_cnt_next;
    logic             burst_live_reg, burst_live_next;
    logic             rd_pend_reg,    rd_pend_next;
    logic             rd_id_reg,      rd_id_next;

    logic gnt_valid;
    logic gnt_id;
    logic locked;

    assign req_valid    = {bus.r1_valid, bus.r0_valid};
    assign req_we       = {bus.r1_we, bus.r0_we};
    assign req_addr[0]  = bus.r0_addr;
    assign req_addr[1]  = bus.r1_addr;
    assign req_wdata[0] = bus.r0_wdata;
    assign req_wdata[1] = bus.r1_wdata;

    // The lock only holds while a burst is actually running; fresh contention after
    // reset or an idle cycle is plain round-robin, so requester 0 wins first out of reset.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        locked    = burst_live_reg && (burst_cnt_reg < BURST_LIMIT);
        if (!rst) begin
            case (req_valid)
                2'b01: begin
                    gnt_valid = 1'b1;
                    gnt_id    = 1'b0;
                end
                2'b10: begin
                    gnt_valid = 1'b1;
                    gnt_id    = 1'b1;
                end
                2'b11: begin
                    gnt_valid = 1'b1;
                    gnt_id    = locked ? last_gnt_reg : ~last_gnt_reg;
                end
                default: begin
                    gnt_valid = 1'b0;
                    gnt_id    = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        last_gnt_next   = last_gnt_reg;
        burst_cnt_next  = '0;
        burst_live_next = 1'b0;
        rd_pend_next    = 1'b0;
        rd_id_next      = rd_id_reg;
        if (gnt_valid) begin
            last_gnt_next   = gnt_id;
            burst_live_next = 1'b1;
            // A lone holder saturates at the limit so it yields as soon as the other asks.
            if (gnt_id == last_gnt_reg) begin
                burst_cnt_next = (burst_cnt_reg == BURST_LIMIT) ? burst_cnt_reg
                                                                : burst_cnt_reg + 1'b1;
            end
            if (!req_we[gnt_id]) begin
                rd_pend_next = 1'b1;
                rd_id_next   = gnt_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_reg   <= 1'b1;
            burst_cnt_reg  <= '0;
            burst_live_reg <= 1'b0;
            rd_pend_reg    <= 1'b0;
            rd_id_reg      <= 1'b0;
        end else begin
            last_gnt_reg   <= last_gnt_next;
            burst_cnt_reg  <= burst_cnt_next;
            burst_live_reg <= burst_live_next;
            rd_pend_reg    <= rd_pend_next;
            rd_id_reg      <= rd_id_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign gnt_vec[gi]    = gnt_valid && (gnt_id == 1'(gi));
            assign rvalid_vec[gi] = rd_pend_reg && (rd_id_reg == 1'(gi));
        end
    endgenerate

    assign bus.r0_ready  = gnt_vec[0];
    assign bus.r1_ready  = gnt_vec[1];
    assign bus.r0_rvalid = rvalid_vec[0];
    assign bus.r1_rvalid = rvalid_vec[1];
    assign bus.r0_rdata  = bus.ram_dout;
    assign bus.r1_rdata  = bus.ram_dout;

    assign bus.ram_en   = gnt_valid;
    assign bus.ram_we   = gnt_valid && req_we[gnt_id];
    assign bus.ram_addr = gnt_valid ? req_addr[gnt_id]  : '0;
    assign bus.ram_din  = gnt_valid ? req_wdata[gnt_id] : '0;
endmodule
